riscv_lsu_gen: RTL and testbench
================================

RISCV_LSU_GEN -- requirements
Module: riscv_lsu_gen

Parameters
REQ-001 The block SHALL have parameter XLEN, default 32, giving data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter AW, default 32, giving address width.
REQ-003 The block SHALL use the derived constant NB = XLEN/8 for bytes per bus beat, and OW = log2(NB) for offset width.

Interface
REQ-004 clk_i  in  1  Single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  Reset, asynchronous and active-low.
REQ-006 core_req_i  in  1  Core requests a load or store.
REQ-007 core_we_i  in  1  1 = store, 0 = load.
REQ-008 core_size_i  in  3  RISC-V funct3 encoding: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
REQ-009 core_addr_i  in  AW  Byte address.
REQ-010 core_wd_i  in  XLEN  Store data, right-aligned.
REQ-011 core_rd_o  out  XLEN  Load result, extended to XLEN.
REQ-012 core_stall_o  out  1  Core must hold its request while this is high.
REQ-013 lsu_err_o  out  1  One-cycle pulse for a misaligned or illegal-size access.
REQ-014 mem_req_o, mem_we_o  out  1 each  Memory request and write enable.
REQ-015 mem_be_o  out  NB  Byte enables.
REQ-016 mem_addr_o  out  AW  Beat-aligned address, with low OW bits zero.
REQ-017 mem_wd_o  out  XLEN  Lane-replicated write data.
REQ-018 mem_rd_i  in  XLEN  Read data, valid when mem_ready_i is high.
REQ-019 mem_ready_i  in  1  Memory completion; it may arrive in the same cycle as mem_req_o or any number of cycles later.

Function
REQ-020 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-021 IDLE with core_req_i=1 and a legal, aligned access: capture we, size, addr, wd into registers and go to BUSY.
REQ-022 IDLE with core_req_i=1 and an illegal or misaligned access: go to DONE with an error flag set and issue no memory request.
REQ-023 BUSY: drive mem_req_o=1 from the registered request, held stable until mem_ready_i=1.
REQ-024 BUSY with mem_ready_i=1: register the formatted load data into core_rd_o (stores leave core_rd_o unchanged) and go to DONE.
REQ-025 DONE: core_stall_o=0; lsu_err_o equals the error flag; next state is IDLE unconditionally.
REQ-026 core_stall_o SHALL equal core_req_i AND (state != DONE), combinationally.
REQ-027 Minimum latency is 3 cycles from the request to the DONE cycle, with stall high for 2 cycles, when mem_ready_i is high in the first BUSY cycle.
REQ-028 Size legality: sizes 3 and 6 are legal only for XLEN=64; size 7 is always illegal.
REQ-029 Alignment: the low log2(bytes) bits of the address SHALL be zero, otherwise the access is misaligned.
REQ-030 mem_be_o = ((1<<bytes)-1) << off, where off = addr[OW-1:0].
REQ-031 mem_wd_o SHALL replicate core_wd_i[8*bytes-1:0] across all lanes.
REQ-032 Load data = mem_rd_i >> (8*off), truncated to size, then sign-extended for sizes 0, 1, 2 and zero-extended for sizes 4, 5, 6.
REQ-033 Outside BUSY, mem_req_o, mem_we_o and mem_be_o SHALL be 0.
REQ-034 mem_ready_i SHALL be ignored outside BUSY.
REQ-035 core_req_i changes during BUSY SHALL be ignored, because the registered request is used.

Reset
REQ-036 When rst_i=0, immediately and asynchronously: state goes to IDLE; core_rd_o, mem_addr_o, mem_wd_o and all captured registers clear to 0; mem_req_o, mem_we_o, mem_be_o and lsu_err_o go to 0.
REQ-037 A reset during BUSY SHALL abort the transaction with no completion; after release, a new request starts from IDLE.

Verification
REQ-038 XLEN=32, load size=0 at addr 0x103, mem_rd_i=0x80AABBCC, ready in the first BUSY cycle -> mem_addr_o=0x100, be=4'b1000, core_rd_o=0xFFFFFF80 in DONE, stall high for exactly 2 cycles.
REQ-039 XLEN=32, store size=1 at addr 0x22, wd=0x1234ABCD -> mem_be_o=4'b1100, mem_wd_o=0xABCDABCD, mem_we_o=1.
REQ-040 Load size=2 at addr 0x6 -> lsu_err_o pulses 1 in the second cycle, mem_req_o is never 1, and stall is released after 1 cycle.
REQ-041 XLEN=64, load size=6 at addr 0x4, mem_rd_i=0x89ABCDEF_01234567 -> be=8'hF0, core_rd_o=0x00000000_89ABCDEF; size=3 under XLEN=32 -> lsu_err_o=1.
REQ-042 mem_ready_i delayed 5 cycles -> mem_req_o, mem_addr_o and mem_be_o held constant for 6 cycles, and changes to core_addr_i meanwhile are ignored.
REQ-043 rst_i driven low in the third BUSY cycle -> mem_req_o=0 in the same cycle before any clock edge, and no DONE cycle occurs.

Source files
------------

// File: rtl/riscv_lsu_gen.sv
// RISC-V load/store unit: checks size/alignment, issues one beat-aligned memory
// access per request, and returns extended load data after completion.
module riscv_lsu_gen #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [AW-1:0]     core_addr_i,
  input  logic [XLEN-1:0]   core_wd_i,
  output logic [XLEN-1:0]   core_rd_o,
  output logic              core_stall_o,
  output logic              lsu_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [XLEN-1:0]   mem_wd_o,
  input  logic [XLEN-1:0]   mem_rd_i,
  input  logic              mem_ready_i,
  output logic [1:0]        dbg_state_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [2:0]        r_size;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wd;
  logic              r_err;
  logic [XLEN-1:0]   r_rd;

  logic              w_size_ok;
  logic              w_aligned;
  logic              w_accept;
  logic [OW-1:0]     w_off;
  logic [3:0]        w_bytes;
  logic [6:0]        w_nbits;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wd;
  logic [XLEN-1:0]   w_shift;
  logic              w_ext;
  logic [XLEN-1:0]   w_ld;

  // Request legality is judged on the live core inputs, only while IDLE.
  always_comb begin
    w_size_ok = 1'b1;
    case (core_size_i)
      3'd3, 3'd6: w_size_ok = (XLEN == 64);
      3'd7:       w_size_ok = 1'b0;
      default:    w_size_ok = 1'b1;
    endcase
    w_aligned = 1'b1;
    case (core_size_i[1:0])
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = (core_addr_i[0] == 1'b0);
      2'd2:    w_aligned = (core_addr_i[1:0] == 2'b00);
      default: w_aligned = (core_addr_i[2:0] == 3'b000);
    endcase
    w_accept = w_size_ok && w_aligned;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (core_req_i) w_next = w_accept ? S_BUSY : S_DONE;
      S_BUSY: if (mem_ready_i) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = (r_state == S_BUSY);
    mem_we_o     = (r_state == S_BUSY) && r_we;
    mem_be_o     = (r_state == S_BUSY) ? w_be : '0;
    core_stall_o = core_req_i && (r_state != S_DONE);
    lsu_err_o    = (r_state == S_DONE) && r_err;
    dbg_state_o  = r_state;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we   <= 1'b0;
      r_size <= 3'd0;
      r_addr <= '0;
      r_wd   <= '0;
      r_err  <= 1'b0;
      r_rd   <= '0;
    end else begin
      if (r_state == S_IDLE && core_req_i) begin
        r_err <= !w_accept;
        if (w_accept) begin
          r_we   <= core_we_i;
          r_size <= core_size_i;
          r_addr <= core_addr_i;
          r_wd   <= core_wd_i;
        end
      end
      if (r_state == S_BUSY && mem_ready_i && !r_we) r_rd <= w_ld;
    end
  end

  assign w_off   = r_addr[OW-1:0];
  assign w_bytes = 4'd1 << r_size[1:0];
  assign w_nbits = 7'd8 << r_size[1:0];

  // Byte enables cover [off, off+bytes); alignment guarantees no wrap.
  always_comb begin
    w_be = '0;
    for (int i = 0; i < NB; i++)
      w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_bytes));
  end

  always_comb begin
    w_wd = '0;
    for (int i = 0; i < NB; i++)
      w_wd[8*i +: 8] = r_wd[8*(i & (int'(w_bytes) - 1)) +: 8];
  end

  assign w_shift = mem_rd_i >> {w_off, 3'b000};

  // Sizes 4..6 (bit 2 set) are the unsigned loads.
  always_comb begin
    case (r_size[1:0])
      2'd0:    w_ext = w_shift[7];
      2'd1:    w_ext = w_shift[15];
      default: w_ext = w_shift[31];
    endcase
    w_ext = w_ext && !r_size[2];
    w_ld  = '0;
    for (int i = 0; i < XLEN; i++)
      w_ld[i] = (i < int'(w_nbits)) ? w_shift[i] : w_ext;
  end

  assign core_rd_o  = r_rd;
  assign mem_addr_o = {r_addr[AW-1:OW], {OW{1'b0}}};
  assign mem_wd_o   = w_wd;

endmodule

// File: tb/tb_riscv_lsu_gen.sv
// Bench for riscv_lsu_gen: one XLEN=32 and one XLEN=64 instance, directed and
// random transactions, load results checked through an expected queue.
module tb_riscv_lsu_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel64;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [63:0] core_wd;
  logic [63:0] mem_rd;
  logic        mem_ready;

  logic        req32, req64, rdy32, rdy64;
  logic [31:0] rd32, maddr32, mwd32;
  logic [63:0] rd64, mwd64;
  logic [31:0] maddr64;
  logic [3:0]  be32;
  logic [7:0]  be64;
  logic        stall32, stall64, err32, err64, mreq32, mreq64, mwe32, mwe64;
  logic [1:0]  st32, st64;

  logic [63:0] o_rd, o_wd;
  logic [31:0] o_maddr;
  logic [7:0]  o_be;
  logic        o_stall, o_err, o_mreq, o_mwe;
  logic [1:0]  o_st;

  logic [63:0] exp_q[$];
  logic [63:0] rd_model32, rd_model64;
  int          n_cmp, n_err;

  always #5 clk = ~clk;

  assign req32 = core_req & ~sel64;
  assign req64 = core_req & sel64;
  assign rdy32 = mem_ready & ~sel64;
  assign rdy64 = mem_ready & sel64;

  riscv_lsu_gen #(.XLEN(32), .AW(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst_n), .core_req_i(req32), .core_we_i(core_we),
    .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd[31:0]),
    .core_rd_o(rd32), .core_stall_o(stall32), .lsu_err_o(err32),
    .mem_req_o(mreq32), .mem_we_o(mwe32), .mem_be_o(be32), .mem_addr_o(maddr32),
    .mem_wd_o(mwd32), .mem_rd_i(mem_rd[31:0]), .mem_ready_i(rdy32),
    .dbg_state_o(st32)
  );

  riscv_lsu_gen #(.XLEN(64), .AW(32)) u_dut64 (
    .clk_i(clk), .rst_i(rst_n), .core_req_i(req64), .core_we_i(core_we),
    .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd64), .core_stall_o(stall64), .lsu_err_o(err64),
    .mem_req_o(mreq64), .mem_we_o(mwe64), .mem_be_o(be64), .mem_addr_o(maddr64),
    .mem_wd_o(mwd64), .mem_rd_i(mem_rd), .mem_ready_i(rdy64),
    .dbg_state_o(st64)
  );

  always_comb begin
    o_rd    = sel64 ? rd64 : {32'd0, rd32};
    o_wd    = sel64 ? mwd64 : {32'd0, mwd32};
    o_maddr = sel64 ? maddr64 : maddr32;
    o_be    = sel64 ? be64 : {4'd0, be32};
    o_stall = sel64 ? stall64 : stall32;
    o_err   = sel64 ? err64 : err32;
    o_mreq  = sel64 ? mreq64 : mreq32;
    o_mwe   = sel64 ? mwe64 : mwe32;
    o_st    = sel64 ? st64 : st32;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a rising edge with the DUT in IDLE.
  task automatic txn(input logic s64, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [63:0] wd,
                     input logic [63:0] rdata, input int delay, input logic exp_err,
                     input logic [31:0] exp_maddr, input logic [7:0] exp_be,
                     input logic [63:0] exp_wd, input logic [63:0] exp_rd);
    int stalls;
    logic [63:0] got;
    stalls = 0;
    sel64 = s64; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_rd = rdata; mem_ready = 1'b0; core_req = 1'b1;
    if (!we && !exp_err) begin
      if (s64) rd_model64 = exp_rd;
      else     rd_model32 = exp_rd;
    end
    exp_q.push_back(s64 ? rd_model64 : rd_model32);
    @(negedge clk);
    if (o_stall) stalls++;
    check("idle_mreq", {63'd0, o_mreq}, 64'd0);
    @(posedge clk); #1;
    if (!exp_err) begin
      for (int k = 0; k <= delay; k++) begin
        mem_ready = (k == delay);
        core_addr = $urandom;
        @(negedge clk);
        if (o_stall) stalls++;
        check("busy_mreq", {63'd0, o_mreq}, 64'd1);
        check("busy_maddr", {32'd0, o_maddr}, {32'd0, exp_maddr});
        check("busy_be", {56'd0, o_be}, {56'd0, exp_be});
        check("busy_mwe", {63'd0, o_mwe}, {63'd0, we});
        if (we) check("busy_mwd", o_wd, exp_wd);
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("done_state", {62'd0, o_st}, 64'd2);
    check("done_err", {63'd0, o_err}, {63'd0, exp_err});
    check("done_stall", {63'd0, o_stall}, 64'd0);
    check("done_mreq", {63'd0, o_mreq}, 64'd0);
    got = exp_q.pop_front();
    check("done_rd", o_rd, got);
    check("stall_cycles", 64'(stalls), exp_err ? 64'd1 : 64'(delay + 2));
    core_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("after_state", {62'd0, o_st}, 64'd0);
    check("after_err", {63'd0, o_err}, 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] mdl_load(input logic [2:0] size, input int off,
                                           input logic [63:0] rdata);
    int nb;
    logic [63:0] v, m;
    nb = 1 << size[1:0];
    v  = rdata >> (8 * off);
    m  = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v  = v & m;
    if (!size[2] && v[8*nb-1]) v = v | ~m;
    return v & 64'h0000_0000_FFFF_FFFF;
  endfunction

  initial begin
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [63:0] r_wd, r_rdata, e_wd;
    logic [7:0]  e_be;
    int          nb, off, dly;
    logic        r_we;
    n_cmp = 0; n_err = 0;
    rd_model32 = '0; rd_model64 = '0;
    sel64 = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
    core_addr = '0; core_wd = '0; mem_rd = '0; mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_state32", {62'd0, st32}, 64'd0);
    check("rst_rd32", {32'd0, rd32}, 64'd0);
    check("rst_maddr32", {32'd0, maddr32}, 64'd0);
    check("rst_mwd64", mwd64, 64'd0);
    check("rst_mreq64", {63'd0, mreq64}, 64'd0);
    check("rst_err32", {63'd0, err32}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // XLEN=32 directed cases
    txn(0, 0, 3'd0, 32'h103, 64'd0, 64'h80AABBCC, 0, 0, 32'h100, 8'h08, 64'd0, 64'hFFFF_FFFF_FFFF_FF80 & 64'hFFFF_FFFF);
    txn(0, 1, 3'd1, 32'h22, 64'h1234ABCD, 64'd0, 0, 0, 32'h20, 8'h0C, 64'hABCDABCD, 64'd0);
    txn(0, 0, 3'd2, 32'h6, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(0, 0, 3'd3, 32'h8, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(0, 0, 3'd6, 32'h4, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(0, 0, 3'd7, 32'h0, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(0, 0, 3'd1, 32'h1, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(0, 0, 3'd5, 32'h1A, 64'd0, 64'h8001F00D, 5, 0, 32'h18, 8'h0C, 64'd0, 64'h8001);
    txn(0, 0, 3'd4, 32'h41, 64'd0, 64'h00009A00, 1, 0, 32'h40, 8'h02, 64'd0, 64'h9A);
    txn(0, 0, 3'd1, 32'h12, 64'd0, 64'hC3C40000, 0, 0, 32'h10, 8'h0C, 64'd0, 64'hFFFFC3C4);
    txn(0, 0, 3'd2, 32'h80, 64'd0, 64'h76543210, 2, 0, 32'h80, 8'h0F, 64'd0, 64'h76543210);
    txn(0, 1, 3'd0, 32'h5, 64'h777777A5, 64'd0, 0, 0, 32'h4, 8'h02, 64'hA5A5A5A5, 64'd0);
    txn(0, 1, 3'd2, 32'h8, 64'hDEADBEEF, 64'd0, 3, 0, 32'h8, 8'h0F, 64'hDEADBEEF, 64'd0);

    // XLEN=64 directed cases
    txn(1, 0, 3'd6, 32'h4, 64'd0, 64'h89ABCDEF_01234567, 0, 0, 32'h0, 8'hF0, 64'd0, 64'h00000000_89ABCDEF);
    txn(1, 1, 3'd3, 32'h10, 64'h01234567_89ABCDEF, 64'd0, 1, 0, 32'h10, 8'hFF, 64'h01234567_89ABCDEF, 64'd0);
    txn(1, 0, 3'd2, 32'h4, 64'd0, 64'h80000001_00000000, 0, 0, 32'h0, 8'hF0, 64'd0, 64'hFFFFFFFF_80000001);
    txn(1, 0, 3'd3, 32'h8, 64'd0, 64'h11223344_55667788, 2, 0, 32'h8, 8'hFF, 64'd0, 64'h11223344_55667788);
    txn(1, 0, 3'd3, 32'h4, 64'd0, 64'd0, 0, 1, 32'd0, 8'd0, 64'd0, 64'd0);
    txn(1, 1, 3'd1, 32'h6, 64'h5A5A_C0DE, 64'd0, 0, 0, 32'h0, 8'hC0, 64'hC0DEC0DE_C0DEC0DE, 64'd0);

    // mem_ready outside BUSY must not move the FSM or touch core_rd_o
    sel64 = 1'b0; mem_ready = 1'b1; mem_rd = 64'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1; mem_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_state", {62'd0, st32}, 64'd0);
    check("stray_ready_rd", {32'd0, rd32}, rd_model32);
    @(posedge clk); #1;

    // Reset in the third BUSY cycle aborts the load
    sel64 = 1'b0; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
    mem_rd = 64'h1111_2222; mem_ready = 1'b0; core_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_state", {62'd0, st32}, 64'd1);
    rst_n = 1'b0; core_req = 1'b0;
    #1;
    check("rst_busy_mreq", {63'd0, mreq32}, 64'd0);
    check("rst_busy_be", {60'd0, be32}, 64'd0);
    check("rst_busy_maddr", {32'd0, maddr32}, 64'd0);
    check("rst_busy_rd", {32'd0, rd32}, 64'd0);
    rd_model32 = '0; rd_model64 = '0;
    @(negedge clk); rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_done", {62'd0, st32}, 64'd0);
    end
    @(posedge clk); #1; mem_ready = 1'b0;

    // Random legal transactions on the 32-bit instance
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 4))
        0: r_size = 3'd0;
        1: r_size = 3'd1;
        2: r_size = 3'd2;
        3: r_size = 3'd4;
        default: r_size = 3'd5;
      endcase
      nb     = 1 << r_size[1:0];
      off    = $urandom_range(0, 4 / nb - 1) * nb;
      r_addr = ($urandom & 32'hFFF0) | 32'(off);
      r_we   = 1'($urandom_range(0, 1));
      r_wd   = {32'd0, $urandom};
      r_rdata = {32'd0, $urandom};
      dly    = $urandom_range(0, 3);
      e_be   = 8'(((1 << nb) - 1) << off);
      case (nb)
        1:       e_wd = {32'd0, {4{r_wd[7:0]}}};
        2:       e_wd = {32'd0, {2{r_wd[15:0]}}};
        default: e_wd = r_wd;
      endcase
      txn(0, r_we, r_size, r_addr, r_wd, r_rdata, dly, 0, r_addr & 32'hFFFF_FFFC,
          e_be, e_wd, mdl_load(r_size, off, r_rdata));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
